ad_frame_reader: RTL

- Consumer end of the acquisition buffer's packed-sample stream.
- Captures the 16-bit dual-sample words while an acquisition runs and stores them in an internal frame RAM.
- When the acquisition ends, emits one framed packet (3 header words, then payload) on a valid/ready stream toward the host/USB transmit path.
- Sits between the AD buffer and the host transmit FIFO, in the i_ad_clk domain.

---
 rtl/ad_frame_reader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ad_frame_reader.sv
// Captures packed dual-sample words during an acquisition and replays them as one framed packet (3 header words + payload).
// Registered output with one-word RAM prefetch: one word per cycle under i_tx_ready; holds data/last/valid while stalled.
module ad_frame_reader #(
    parameter int          AW       = 10,
    parameter logic [15:0] HDR_SYNC = 16'hA55A
) (
    input  logic        i_ad_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_dual_data,
    input  logic        i_data_on,
    input  logic        i_working,
    output logic [15:0] o_tx_data,
    output logic        o_tx_valid,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_missed
);

    typedef enum logic [2:0] {IDLE, CAPTURE, HDR0, HDR1, HDR2, DATA} state_t;

    state_t      state, state_nxt;
    logic        w_d;
    logic        start, stop;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        ovf;
    logic [15:0] seq;
    logic [15:0] hdr2_word;
    logic        empty;

    logic [15:0] mem [2**AW];
    logic [15:0] ram_q;
    logic        p_vld, p_last;

    logic        xfer, out_free;
    logic        wr_en, rd_en, fetch_state;
    logic        clr_cap, rd_clr, p_take, seq_inc;
    logic        load_en, load_vld, load_last;
    logic [15:0] load_dat;

    assign start     = i_working && !w_d;
    assign stop      = !i_working && w_d;
    assign xfer      = o_tx_valid && i_tx_ready;
    assign out_free  = !o_tx_valid || i_tx_ready;
    assign empty     = (wr_ptr == '0);
    assign hdr2_word = {ovf, 15'(wr_ptr)};

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        clr_cap   = 1'b0;
        rd_clr    = 1'b0;
        p_take    = 1'b0;
        seq_inc   = 1'b0;
        load_en   = 1'b0;
        load_vld  = 1'b0;
        load_dat  = '0;
        load_last = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    clr_cap   = 1'b1;
                end
            end
            CAPTURE: begin
                wr_en = i_data_on;
                if (stop) begin
                    state_nxt = HDR0;
                    rd_clr    = 1'b1;
                    load_en   = 1'b1;
                    load_vld  = 1'b1;
                    load_dat  = HDR_SYNC;
                end
            end
            HDR0: begin
                if (xfer) begin
                    state_nxt = HDR1;
                    load_en   = 1'b1;
                    load_vld  = 1'b1;
                    load_dat  = seq;
                end
            end
            HDR1: begin
                if (xfer) begin
                    state_nxt = HDR2;
                    load_en   = 1'b1;
                    load_vld  = 1'b1;
                    load_dat  = hdr2_word;
                    load_last = empty;
                end
            end
            HDR2: begin
                if (xfer) begin
                    load_en = 1'b1;
                    if (empty) begin
                        state_nxt = IDLE;
                    end else begin
                        // first payload word was prefetched during the header
                        state_nxt = DATA;
                        p_take    = p_vld;
                        load_vld  = p_vld;
                        load_dat  = ram_q;
                        load_last = p_last;
                    end
                end
            end
            DATA: begin
                if (out_free) begin
                    load_en = 1'b1;
                    if (o_tx_valid && o_tx_last) begin
                        state_nxt = IDLE;
                        seq_inc   = 1'b1;
                    end else if (p_vld) begin
                        p_take    = 1'b1;
                        load_vld  = 1'b1;
                        load_dat  = ram_q;
                        load_last = p_last;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM output doubles as the prefetch register: only read when it is empty or being drained
    assign fetch_state = (state == HDR0) || (state == HDR1) || (state == HDR2) || (state == DATA);
    assign rd_en       = fetch_state && (rd_ptr < wr_ptr) && (!p_vld || p_take);

    always_ff @(posedge i_ad_clk) begin
        if (wr_en && !wr_ptr[AW]) begin
            mem[wr_ptr[AW-1:0]] <= i_dual_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            w_d        <= 1'b0;
            o_busy     <= 1'b0;
            o_missed   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ovf        <= 1'b0;
            seq        <= '0;
            p_vld      <= 1'b0;
            p_last     <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
            o_tx_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            w_d      <= i_working;
            o_busy   <= (state_nxt != IDLE);
            o_missed <= start && (state != IDLE);

            if (clr_cap) begin
                wr_ptr <= '0;
                ovf    <= 1'b0;
            end else if (wr_en) begin
                if (!wr_ptr[AW]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end

            if (rd_clr) begin
                rd_ptr <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (rd_clr) begin
                p_vld <= 1'b0;
            end else if (rd_en) begin
                p_vld  <= 1'b1;
                p_last <= ((rd_ptr + 1'b1) == wr_ptr);
            end else if (p_take) begin
                p_vld <= 1'b0;
            end

            if (load_en) begin
                o_tx_valid <= load_vld;
                o_tx_data  <= load_dat;
                o_tx_last  <= load_last;
            end

            if (seq_inc) begin
                seq <= seq + 16'd1;
            end
        end
    end

endmodule
